// File: rtl/flt2int_pkg.sv
// Shared types and width helpers for the float-to-integer converter.
package flt2int_pkg;

  typedef enum logic [2:0] {IDLE, PREP, SHIFT, ROUND, DONE} state_e;

  typedef enum logic [1:0] {RNE, RTZ, FLOOR, CEIL} rnd_mode_e;

  // Largest positive two's-complement value of a w-bit integer.
  function automatic logic [63:0] int_max_mag(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Magnitude of the most negative w-bit integer (also its bit pattern).
  function automatic logic [63:0] int_min_mag(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/flt2int_seq_if.sv
// Sequencer-side handshake and data bus of the float-to-integer coprocessor.
interface flt2int_seq_if #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10,
  parameter int unsigned INT_W = 16
);
  localparam int unsigned FLT_W = 1 + EXP_W + MAN_W;

  logic             start;
  logic [FLT_W-1:0] flt_in;
  logic [1:0]       rnd_mode;
  logic             busy;
  logic             done;
  logic [INT_W-1:0] int_out;
  logic             ovf;
  logic             inexact;

  modport master (output start, flt_in, rnd_mode,
                  input  busy, done, int_out, ovf, inexact);
  modport slave  (input  start, flt_in, rnd_mode,
                  output busy, done, int_out, ovf, inexact);
endinterface

// File: rtl/flt2int_round.sv
// Rounding-increment decision from sign, lsb, guard and sticky.
module flt2int_round
  import flt2int_pkg::*;
(
  input  logic      i_sign,
  input  logic      i_lsb,
  input  logic      i_guard,
  input  logic      i_sticky,
  input  rnd_mode_e i_mode,
  output logic      o_inc_c
);

  // Select the increment rule for the active rounding mode.
  always_comb begin
    o_inc_c = 1'b0;
    case (i_mode)
      RNE:     o_inc_c = i_guard & (i_lsb | i_sticky);
      RTZ:     o_inc_c = 1'b0;
      FLOOR:   o_inc_c = i_sign & (i_guard | i_sticky);
      CEIL:    o_inc_c = ~i_sign & (i_guard | i_sticky);
      default: o_inc_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/flt2int_seq.sv
// Sequential float-to-integer converter with saturation and rounding flags.
// Define FLT2INT_BARREL_SHIFT_EN for a single-cycle barrel SHIFT stage;
// otherwise the magnitude is shifted one bit per cycle.
module flt2int_seq
  import flt2int_pkg::*;
#(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10,
  parameter int unsigned INT_W = 16,
  parameter int unsigned BIAS  = 15
) (
  input  logic         clk,
  input  logic         reset,
  flt2int_seq_if.slave bus
);

  localparam int unsigned FLT_W = 1 + EXP_W + MAN_W;
  localparam int unsigned MAG_W = INT_W + 1;
  localparam int unsigned CNT_W = $clog2(MAN_W + INT_W + 3);

  localparam logic [INT_W-1:0] MAX_V   = INT_W'(int_max_mag(INT_W));
  localparam logic [INT_W-1:0] MIN_V   = INT_W'(int_min_mag(INT_W));
  localparam logic [MAG_W-1:0] MAX_MAG = MAG_W'(int_max_mag(INT_W));
  localparam logic [MAG_W-1:0] MIN_MAG = MAG_W'(int_min_mag(INT_W));

  state_e             r_state, w_state_nxt;
  logic               r_sign, w_sign_nxt;
  logic [EXP_W-1:0]   r_exp, w_exp_nxt;
  logic [MAN_W-1:0]   r_frac, w_frac_nxt;
  rnd_mode_e          r_mode, w_mode_nxt;
  logic [MAG_W-1:0]   r_mag, w_mag_nxt;
  logic               r_g, w_g_nxt;
  logic               r_s, w_s_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_left, w_left_nxt;
  logic [INT_W-1:0]   r_res, w_res_nxt;
  logic               r_ovf_p, w_ovf_p_nxt;
  logic               r_inx_p, w_inx_p_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic [INT_W-1:0]   r_int, w_int_nxt;
  logic               r_ovf, w_ovf_nxt;
  logic               r_inx, w_inx_nxt;

  logic [MAN_W:0]     w_mant;
  int                 w_u;
  int                 w_n;
  logic               w_inc_c;
  logic [MAG_W-1:0]   w_mag_r;
  logic [MAG_W-1:0]   w_neg;

  assign w_mant  = {(r_exp != '0), r_frac};
  assign w_u     = (r_exp == '0) ? (1 - int'(BIAS)) : (int'(r_exp) - int'(BIAS));
  assign w_mag_r = r_mag + MAG_W'(w_inc_c);
  assign w_neg   = ~w_mag_r + MAG_W'(1);

  flt2int_round u_round (
    .i_sign   (r_sign),
    .i_lsb    (r_mag[0]),
    .i_guard  (r_g),
    .i_sticky (r_s),
    .i_mode   (r_mode),
    .o_inc_c  (w_inc_c)
  );

`ifdef FLT2INT_BARREL_SHIFT_EN
  logic w_bg, w_bs;

  // Guard is bit n-1 of the pre-shift magnitude; sticky ORs all bits below it.
  always_comb begin
    w_bg = 1'b0;
    w_bs = 1'b0;
    for (int i = 0; i < int'(MAG_W); i++) begin
      if (int'(r_cnt) == i + 1)     w_bg = r_mag[i];
      else if (int'(r_cnt) > i + 1) w_bs = w_bs | r_mag[i];
    end
  end
`endif

  // Next-state and datapath update for the conversion sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_sign_nxt  = r_sign;
    w_exp_nxt   = r_exp;
    w_frac_nxt  = r_frac;
    w_mode_nxt  = r_mode;
    w_mag_nxt   = r_mag;
    w_g_nxt     = r_g;
    w_s_nxt     = r_s;
    w_cnt_nxt   = r_cnt;
    w_left_nxt  = r_left;
    w_res_nxt   = r_res;
    w_ovf_p_nxt = r_ovf_p;
    w_inx_p_nxt = r_inx_p;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_int_nxt   = r_int;
    w_ovf_nxt   = r_ovf;
    w_inx_nxt   = r_inx;
    w_n         = 0;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_sign_nxt  = bus.flt_in[FLT_W-1];
          w_exp_nxt   = bus.flt_in[MAN_W +: EXP_W];
          w_frac_nxt  = bus.flt_in[MAN_W-1:0];
          w_mode_nxt  = rnd_mode_e'(bus.rnd_mode);
          w_busy_nxt  = 1'b1;
          w_state_nxt = PREP;
        end
      end

      PREP: begin
        w_mag_nxt   = MAG_W'(w_mant);
        w_g_nxt     = 1'b0;
        w_s_nxt     = 1'b0;
        w_ovf_p_nxt = 1'b0;
        w_inx_p_nxt = 1'b0;
        if (r_exp == '1) begin
          // Infinity saturates by sign; NaN always reports MAX.
          w_res_nxt   = (r_sign && r_frac == '0) ? MIN_V : MAX_V;
          w_ovf_p_nxt = 1'b1;
          w_state_nxt = DONE;
        end else if (w_u > int'(INT_W) - 1 ||
                     (w_u == int'(INT_W) - 1 && !(r_sign && r_frac == '0))) begin
          w_res_nxt   = r_sign ? MIN_V : MAX_V;
          w_ovf_p_nxt = 1'b1;
          w_state_nxt = DONE;
        end else if (w_u == int'(INT_W) - 1) begin
          // Exactly -2^(INT_W-1) is representable.
          w_res_nxt   = MIN_V;
          w_state_nxt = DONE;
        end else begin
          if (w_u >= int'(MAN_W)) begin
            w_left_nxt = 1'b1;
            w_n        = w_u - int'(MAN_W);
          end else begin
            // Beyond MAN_W+2 places all bits have already reached sticky.
            w_left_nxt = 1'b0;
            w_n        = int'(MAN_W) - w_u;
            if (w_n > int'(MAN_W) + 2) w_n = int'(MAN_W) + 2;
          end
          w_cnt_nxt = CNT_W'(w_n);
`ifdef FLT2INT_BARREL_SHIFT_EN
          w_state_nxt = SHIFT;
`else
          w_state_nxt = (w_n == 0) ? ROUND : SHIFT;
`endif
        end
      end

      SHIFT: begin
`ifdef FLT2INT_BARREL_SHIFT_EN
        if (r_left) begin
          w_mag_nxt = r_mag << r_cnt;
        end else begin
          w_mag_nxt = r_mag >> r_cnt;
          w_g_nxt   = w_bg;
          w_s_nxt   = w_bs;
        end
        w_state_nxt = ROUND;
`else
        if (r_left) begin
          w_mag_nxt = r_mag << 1;
        end else begin
          w_mag_nxt = r_mag >> 1;
          w_g_nxt   = r_mag[0];
          w_s_nxt   = r_s | r_g;
        end
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) w_state_nxt = ROUND;
`endif
      end

      ROUND: begin
        w_inx_p_nxt = r_g | r_s;
        if (!r_sign && w_mag_r > MAX_MAG) begin
          w_res_nxt   = MAX_V;
          w_ovf_p_nxt = 1'b1;
        end else if (r_sign && w_mag_r > MIN_MAG) begin
          w_res_nxt   = MIN_V;
          w_ovf_p_nxt = 1'b1;
        end else begin
          w_res_nxt = r_sign ? INT_W'(w_neg) : INT_W'(w_mag_r);
        end
        w_state_nxt = DONE;
      end

      DONE: begin
        w_int_nxt   = r_res;
        w_ovf_nxt   = r_ovf_p;
        w_inx_nxt   = r_inx_p;
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_sign  <= 1'b0;
      r_exp   <= '0;
      r_frac  <= '0;
      r_mode  <= RNE;
      r_mag   <= '0;
      r_g     <= 1'b0;
      r_s     <= 1'b0;
      r_cnt   <= '0;
      r_left  <= 1'b0;
      r_res   <= '0;
      r_ovf_p <= 1'b0;
      r_inx_p <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_int   <= '0;
      r_ovf   <= 1'b0;
      r_inx   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sign  <= w_sign_nxt;
      r_exp   <= w_exp_nxt;
      r_frac  <= w_frac_nxt;
      r_mode  <= w_mode_nxt;
      r_mag   <= w_mag_nxt;
      r_g     <= w_g_nxt;
      r_s     <= w_s_nxt;
      r_cnt   <= w_cnt_nxt;
      r_left  <= w_left_nxt;
      r_res   <= w_res_nxt;
      r_ovf_p <= w_ovf_p_nxt;
      r_inx_p <= w_inx_p_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_int   <= w_int_nxt;
      r_ovf   <= w_ovf_nxt;
      r_inx   <= w_inx_nxt;
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.int_out = r_int;
  assign bus.ovf     = r_ovf;
  assign bus.inexact = r_inx;

endmodule

// File: tb/tb_flt2int_seq.sv
// Directed bench for flt2int_seq (half precision to int16).
module tb_flt2int_seq;
  import flt2int_pkg::*;

  localparam int unsigned EXP_W = 5;
  localparam int unsigned MAN_W = 10;
  localparam int unsigned INT_W = 16;
  localparam int unsigned BIAS  = 15;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   dones;
  logic [15:0] last_int;

  always #5 clk = ~clk;

  flt2int_seq_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .INT_W(INT_W)) bus_if ();

  flt2int_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W), .INT_W(INT_W), .BIAS(BIAS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Edges from acceptance to done; n < 0 marks a special/saturating input.
  function automatic int exp_lat(input int n);
`ifdef FLT2INT_BARREL_SHIFT_EN
    return (n < 0) ? 2 : 4;
`else
    return (n < 0) ? 2 : 3 + n;
`endif
  endfunction

  task automatic convert(input string tag, input logic [15:0] flt, input logic [1:0] mode,
                         input logic [15:0] res, input logic ovf, input logic inx, input int n);
    int cyc;
    @(negedge clk);
    bus_if.start    = 1'b1;
    bus_if.flt_in   = flt;
    bus_if.rnd_mode = mode;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    check({tag, ".busy"}, 32'(bus_if.busy), 32'd1);
    cyc = 0;
    while (bus_if.done !== 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, ".lat"}, 32'(cyc), 32'(exp_lat(n)));
    check({tag, ".int"}, 32'(bus_if.int_out), 32'(res));
    check({tag, ".ovf"}, 32'(bus_if.ovf), 32'(ovf));
    check({tag, ".inx"}, 32'(bus_if.inexact), 32'(inx));
    check({tag, ".busy_off"}, 32'(bus_if.busy), 32'd0);
    @(posedge clk);
    #1;
    check({tag, ".pulse"}, 32'(bus_if.done), 32'd0);
  endtask

  initial begin
    bus_if.start    = 1'b0;
    bus_if.flt_in   = '0;
    bus_if.rnd_mode = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 32'(bus_if.busy), 32'd0);
    check("rst.done", 32'(bus_if.done), 32'd0);
    check("rst.int", 32'(bus_if.int_out), 32'd0);
    check("rst.ovf", 32'(bus_if.ovf), 32'd0);
    check("rst.inx", 32'(bus_if.inexact), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    convert("one_rne",   16'h3C00, RNE,   16'h0001, 1'b0, 1'b0, 10);
    convert("p2p5_rne",  16'h4100, RNE,   16'h0002, 1'b0, 1'b1, 9);
    convert("p2p5_ceil", 16'h4100, CEIL,  16'h0003, 1'b0, 1'b1, 9);
    convert("p2p5_rtz",  16'h4100, RTZ,   16'h0002, 1'b0, 1'b1, 9);
    convert("m2p5_rne",  16'hC100, RNE,   16'hFFFE, 1'b0, 1'b1, 9);
    convert("m2p5_flr",  16'hC100, FLOOR, 16'hFFFD, 1'b0, 1'b1, 9);
    convert("p1p5_rne",  16'h3E00, RNE,   16'h0002, 1'b0, 1'b1, 10);
    convert("half_rne",  16'h3800, RNE,   16'h0000, 1'b0, 1'b1, 11);
    convert("mhalf_flr", 16'hB800, FLOOR, 16'hFFFF, 1'b0, 1'b1, 11);
    convert("p1024",     16'h6400, RNE,   16'h0400, 1'b0, 1'b0, 0);
    convert("p8192",     16'h7000, RNE,   16'h2000, 1'b0, 1'b0, 3);
    convert("min_exact", 16'hF800, RNE,   16'h8000, 1'b0, 1'b0, -1);
    convert("pos_sat",   16'h7800, RNE,   16'h7FFF, 1'b1, 1'b0, -1);
    convert("pinf",      16'h7C00, RNE,   16'h7FFF, 1'b1, 1'b0, -1);
    convert("ninf",      16'hFC00, RNE,   16'h8000, 1'b1, 1'b0, -1);
    convert("nan",       16'h7E00, RNE,   16'h7FFF, 1'b1, 1'b0, -1);
    convert("zero",      16'h0000, RNE,   16'h0000, 1'b0, 1'b0, 12);
    convert("nzero_flr", 16'h8000, FLOOR, 16'h0000, 1'b0, 1'b0, 12);
    convert("den_rne",   16'h0001, RNE,   16'h0000, 1'b0, 1'b1, 12);
    convert("den_ceil",  16'h0001, CEIL,  16'h0001, 1'b0, 1'b1, 12);
    convert("nden_flr",  16'h8001, FLOOR, 16'hFFFF, 1'b0, 1'b1, 12);

    // Reset while the conversion sits in SHIFT.
    @(negedge clk);
    bus_if.start    = 1'b1;
    bus_if.flt_in   = 16'h0001;
    bus_if.rnd_mode = RNE;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort.busy", 32'(bus_if.busy), 32'd0);
    check("abort.done", 32'(bus_if.done), 32'd0);
    check("abort.int", 32'(bus_if.int_out), 32'd0);
    check("abort.ovf", 32'(bus_if.ovf), 32'd0);
    check("abort.inx", 32'(bus_if.inexact), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus_if.done === 1'b1) dones++;
    end
    check("abort.no_done", 32'(dones), 32'd0);

    // A start pulse while busy must not launch a second conversion.
    @(negedge clk);
    bus_if.start    = 1'b1;
    bus_if.flt_in   = 16'h3C00;
    bus_if.rnd_mode = RNE;
    dones    = 0;
    last_int = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.done === 1'b1) begin
        dones++;
        last_int = bus_if.int_out;
      end
      if (i == 0) bus_if.start = 1'b0;
      if (i == 3) begin
        bus_if.start  = 1'b1;
        bus_if.flt_in = 16'h7000;
      end
      if (i == 4) bus_if.start = 1'b0;
    end
    check("busy_start.dones", 32'(dones), 32'd1);
    check("busy_start.int", 32'(last_int), 32'h0001);

    // Start held high re-launches after each done.
    @(negedge clk);
    bus_if.start    = 1'b1;
    bus_if.flt_in   = 16'h4100;
    bus_if.rnd_mode = RTZ;
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus_if.done === 1'b1) dones++;
    end
    bus_if.start = 1'b0;
    check("held_start.multi", 32'(dones >= 2), 32'd1);
    check("held_start.int", 32'(bus_if.int_out), 32'h0002);
    repeat (20) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
